// File: rtl/cim_pkg.sv
// Shared constants for the CIM bit-serial datapath: activation-width encodings,
// last-bit lookup and the shift-accumulator state type.
package cim_pkg;

  localparam logic [1:0] INW_8  = 2'b00;
  localparam logic [1:0] INW_12 = 2'b01;
  localparam logic [1:0] INW_16 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  // Index of the final (MSB) beat for a given activation width; 2'b11 aliases 8b.
  function automatic logic [3:0] last_bit(input logic [1:0] inwidth);
    case (inwidth)
      INW_12:  return 4'd11;
      INW_16:  return 4'd15;
      default: return 4'd7;
    endcase
  endfunction

endpackage

// File: rtl/bs_term_gen.sv
// Weights one partial sum by 2^sel; the MSB beat of a signed activation is negated.
module bs_term_gen #(
  parameter int PSUM_W = 16,
  parameter int OUT_W  = PSUM_W + 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic [PSUM_W-1:0] psum,
  input  logic [3:0]        sel,
  input  logic [3:0]        last,
  output logic [OUT_W-1:0]  term
);

  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] shifted;

  assign ext     = {{(OUT_W-PSUM_W){psum[PSUM_W-1]}}, psum};
  assign shifted = ext << sel;
  assign term    = (SIGNED && (sel == last)) ? (~shifted + 1'b1) : shifted;

endmodule

// File: rtl/bs_shift_acc.sv
// Bit-serial shift-accumulator: sums 2^sel-weighted partial sums over one frame
// of 8/12/16 beats and emits a registered full-precision result.
module bs_shift_acc
  import cim_pkg::*;
#(
  parameter int PSUM_W = 16,
  parameter int OUT_W  = PSUM_W + 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        inwidth,
  input  logic [3:0]        sel,
  input  logic              st,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              psum_vld,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_vld,
  output logic              err,
  output state_e            dbg_state
);

  // psum_vld is a valid-only qualifier with no backpressure: every cycle with
  // psum_vld=1 is a beat and is consumed; a gap inside a frame aborts it.

  state_e           state, state_nxt;
  logic [3:0]       last_q;
  logic [3:0]       exp_bit;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] term;

  logic start, add, finish, abort;

  bs_term_gen #(
    .PSUM_W(PSUM_W),
    .OUT_W (OUT_W),
    .SIGNED(SIGNED)
  ) u_term (
    .psum(psum_in),
    .sel (sel),
    .last(last_q),
    .term(term)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start)               state_nxt = ACC;
    else if (abort || finish) state_nxt = IDLE;
  end

  // A restart inside ACC both aborts the old frame and opens a new one.
  always_comb begin
    start  = 1'b0;
    add    = 1'b0;
    finish = 1'b0;
    abort  = 1'b0;
    case (state)
      IDLE: start = psum_vld && st && (sel == 4'd0);
      ACC: begin
        if (!psum_vld) begin
          abort = 1'b1;
        end else if (st) begin
          abort = 1'b1;
          start = (sel == 4'd0);
        end else if (sel != exp_bit) begin
          abort = 1'b1;
        end else if (sel == last_q) begin
          finish = 1'b1;
        end else begin
          add = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc     <= '0;
      last_q  <= 4'd7;
      exp_bit <= 4'd0;
    end else if (start) begin
      acc     <= term;
      last_q  <= last_bit(inwidth);
      exp_bit <= 4'd1;
    end else if (add) begin
      acc     <= acc + term;
      exp_bit <= exp_bit + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data <= '0;
      out_vld  <= 1'b0;
      err      <= 1'b0;
    end else begin
      out_vld <= finish;
      err     <= abort;
      if (finish) out_data <= acc + term;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_bs_shift_acc.sv
// Bench for bs_shift_acc: a signed and an unsigned instance share stimulus and are
// compared every cycle against a frame-level arithmetic reference.
module tb_bs_shift_acc;
  import cim_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  inwidth = 2'b00;
  logic [3:0]  sel = 4'd0;
  logic        st = 1'b0;
  logic [15:0] psum_in = 16'd0;
  logic        psum_vld = 1'b0;

  logic [31:0] data_s, data_u;
  logic        vld_s, vld_u, err_s, err_u;
  state_e      dbg_s, dbg_u;

  int checks = 0;
  int failures = 0;

  bs_shift_acc #(.PSUM_W(16), .OUT_W(32), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rstn(rstn), .inwidth(inwidth), .sel(sel), .st(st),
    .psum_in(psum_in), .psum_vld(psum_vld),
    .out_data(data_s), .out_vld(vld_s), .err(err_s), .dbg_state(dbg_s)
  );

  bs_shift_acc #(.PSUM_W(16), .OUT_W(32), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rstn(rstn), .inwidth(inwidth), .sel(sel), .st(st),
    .psum_in(psum_in), .psum_vld(psum_vld),
    .out_data(data_u), .out_vld(vld_u), .err(err_u), .dbg_state(dbg_u)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  bit          active = 0;
  longint      frame_q[$];
  int          last_m = 7;
  logic        exp_vld = 0;
  logic        exp_err = 0;
  logic [31:0] exp_q_s[$];
  logic [31:0] exp_q_u[$];
  logic [31:0] hold_s = '0;
  logic [31:0] hold_u = '0;
  logic [15:0] pv[16];

  function automatic int last_of(input logic [1:0] w);
    return (w == 2'b01) ? 11 : (w == 2'b10) ? 15 : 7;
  endfunction

  function automatic logic [31:0] frame_value(input bit signed_mode);
    longint sum = 0;
    longint wgt;
    for (int i = 0; i < frame_q.size(); i++) begin
      wgt = longint'(1) <<< i;
      if (signed_mode && i == last_m) wgt = -wgt;
      sum += frame_q[i] * wgt;
    end
    return sum[31:0];
  endfunction

  task automatic model(input logic v, input logic s, input logic [3:0] b,
                       input logic [15:0] p, input logic [1:0] w);
    bit open_new = 0;
    exp_vld = 0;
    exp_err = 0;
    if (!active) begin
      open_new = v && s && (b == 0);
    end else if (!v) begin
      exp_err = 1; active = 0;
    end else if (s) begin
      exp_err = 1; active = 0; open_new = (b == 0);
    end else if (int'(b) != frame_q.size()) begin
      exp_err = 1; active = 0;
    end else begin
      frame_q.push_back(longint'($signed(p)));
      if (int'(b) == last_m) begin
        exp_q_s.push_back(frame_value(1'b1));
        exp_q_u.push_back(frame_value(1'b0));
        exp_vld = 1; active = 0;
      end
    end
    if (open_new) begin
      frame_q = {};
      frame_q.push_back(longint'($signed(p)));
      last_m = last_of(w);
      active = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    if (exp_q_s.size() > 0) hold_s = exp_q_s.pop_front();
    if (exp_q_u.size() > 0) hold_u = exp_q_u.pop_front();
    chk("vld_s", 32'(vld_s), 32'(exp_vld));
    chk("vld_u", 32'(vld_u), 32'(exp_vld));
    chk("err_s", 32'(err_s), 32'(exp_err));
    chk("err_u", 32'(err_u), 32'(exp_err));
    chk("data_s", data_s, hold_s);
    chk("data_u", data_u, hold_u);
  endtask

  // driver: one clock with the given inputs, then model update and check
  task automatic step(input logic v, input logic s, input logic [3:0] b,
                      input logic [15:0] p, input logic [1:0] w);
    psum_vld = v; st = s; sel = b; psum_in = p; inwidth = w;
    @(posedge clk);
    model(v, s, b, p, w);
    #1;
    check_outputs();
  endtask

  // kind: 0 complete, 1 drop valid, 2 skip a bit, 3 premature restart (then complete)
  task automatic send_frame(input logic [1:0] w, input logic [1:0] w_mid,
                            input int kind, input int pos);
    int last = last_of(w);
    for (int b = 0; b <= last; b++) begin
      if (kind != 0 && b == pos) begin
        if (kind == 1) step(1'b0, 1'b0, 4'(b), pv[b], w);
        if (kind == 2) step(1'b1, 1'b0, 4'(b + 1), pv[b], w);
        if (kind == 3) begin
          step(1'b1, 1'b1, 4'd0, pv[0], w);
          for (int c = 1; c <= last; c++) step(1'b1, 1'b0, 4'(c), pv[c], w);
        end
        return;
      end
      step(1'b1, (b == 0), 4'(b), pv[b], (b >= 2) ? w_mid : w);
    end
  endtask

  task automatic fill_pv(input logic [15:0] val);
    for (int i = 0; i < 16; i++) pv[i] = val;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++)
      step(1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)),
           16'($urandom), 2'($urandom_range(0, 3)));
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_data_s", data_s, 32'd0);
    chk("rst_data_u", data_u, 32'd0);
    chk("rst_vld", 32'(vld_s | vld_u), 32'd0);
    chk("rst_err", 32'(err_s | err_u), 32'd0);
    chk("rst_state", 32'(dbg_s), 32'(IDLE));
    #20 rstn = 1'b1;
    @(negedge clk);

    // 8b frame of ones: -1 signed, 255 unsigned
    fill_pv(16'd1);
    send_frame(2'b00, 2'b00, 0, 0);
    chk("t1_s", data_s, 32'hFFFF_FFFF);
    chk("t1_u", data_u, 32'd255);
    chk("t1_vld", 32'(vld_s), 32'd1);

    // 12b frame of twos
    fill_pv(16'd2);
    send_frame(2'b01, 2'b01, 0, 0);
    chk("t2_u", data_u, 32'd8190);

    // 16b, MSB-only 3 then LSB-only -32768
    fill_pv(16'd0); pv[15] = 16'd3;
    send_frame(2'b10, 2'b10, 0, 0);
    chk("t3a_s", data_s, 32'hFFFE_8000);
    fill_pv(16'd0); pv[0] = 16'h8000;
    send_frame(2'b10, 2'b10, 0, 0);
    chk("t3b_s", data_s, 32'hFFFF_8000);

    // back-to-back 8b frames
    fill_pv(16'd1);
    send_frame(2'b00, 2'b00, 0, 0);
    fill_pv(16'd2);
    send_frame(2'b00, 2'b00, 0, 0);
    chk("t4_s", data_s, 32'hFFFF_FFFE);

    // aborts
    idle_cycles(2);
    fill_pv(16'd5);
    send_frame(2'b00, 2'b00, 1, 3);
    chk("t5a_err", 32'(err_s), 32'd1);
    chk("t5a_hold", data_s, 32'hFFFF_FFFE);
    idle_cycles(1);
    send_frame(2'b00, 2'b00, 2, 5);
    chk("t5b_err", 32'(err_u), 32'd1);
    idle_cycles(1);
    fill_pv(16'd1);
    send_frame(2'b00, 2'b00, 3, 5);
    chk("t5c_s", data_s, 32'hFFFF_FFFF);

    // mid-frame inwidth flip still ends at bit 7
    fill_pv(16'd1);
    send_frame(2'b00, 2'b10, 0, 0);
    chk("t6_u", data_u, 32'd255);

    // reset mid-frame
    fill_pv(16'd7);
    for (int b = 0; b <= 4; b++) step(1'b1, (b == 0), 4'(b), pv[b], 2'b00);
    rstn = 1'b0;
    #1;
    chk("rst_mid_data", data_s | data_u, 32'd0);
    chk("rst_mid_flags", 32'({vld_s, vld_u, err_s, err_u}), 32'd0);
    active = 0; hold_s = '0; hold_u = '0; exp_vld = 0; exp_err = 0;
    #1 rstn = 1'b1;
    fill_pv(16'd1);
    send_frame(2'b00, 2'b00, 0, 0);
    chk("t6r_s", data_s, 32'hFFFF_FFFF);

    // randomized frames
    for (int n = 0; n < 60; n++) begin
      logic [1:0] w;
      int kind;
      w = 2'($urandom_range(0, 3));
      kind = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      for (int i = 0; i < 16; i++) pv[i] = 16'($urandom);
      send_frame(w, 2'($urandom_range(0, 3)), kind, $urandom_range(1, last_of(w)));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard time limit
  initial begin
    #500000;
    failures++;
    $display("FAIL timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
